// File: rtl/ofdm_sync_pkg.sv
// Shared types and helpers for the OFDM frame-synchronisation controller.
package ofdm_sync_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    PEAK,
    ALIGN,
    FRAME,
    HOLD
  } sync_state_t;

  // Width of the sample counters: enough to hold the largest of the three spans.
  function automatic int unsigned cnt_width(input int unsigned frame_ofs,
                                            input int unsigned sym_len,
                                            input int unsigned holdoff);
    int unsigned m;
    m = frame_ofs;
    if (sym_len > m) m = sym_len;
    if (holdoff > m) m = holdoff;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ofdm_sync_ctrl_peak_track.sv
// Running maximum of the correlator magnitude plus the number of samples
// since that maximum was taken. Ties keep the earlier (older) peak.
module ofdm_peak_track #(
  parameter int unsigned MAG_W = 48,
  parameter int unsigned CW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             update,
  input  logic             age_inc,
  input  logic [MAG_W-1:0] mag,
  output logic [MAG_W-1:0] pk_nxt,
  output logic [CW-1:0]    age
);

  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [MAG_W-1:0] pk;

  // Peak value as it will stand after an update with the current sample.
  always_comb begin
    pk_nxt = (mag > pk) ? mag : pk;
  end

  // Peak register and age counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk  <= '0;
      age <= '0;
    end else if (clear) begin
      pk  <= '0;
      age <= '0;
    end else if (load) begin
      pk  <= mag;
      age <= '0;
    end else if (update) begin
      if (mag > pk) begin
        pk  <= mag;
        age <= '0;
      end else begin
        age <= age + C_ONE;
      end
    end else if (age_inc) begin
      age <= age + C_ONE;
    end
  end

endmodule

// File: rtl/ofdm_sync_ctrl.sv
// Frame-synchronisation controller behind the preamble correlator.
// Picks the true correlation peak in a window after the first find, issues
// frame_start FRAME_OFS samples after it, sequences symbol boundaries and
// blocks detection during the frame plus a hold-off period.
// Optional build macro: SYNC_STATS_EN adds frame_cnt / miss_cnt outputs.
module ofdm_sync_ctrl
  import ofdm_sync_pkg::*;
#(
  parameter int unsigned MAG_W     = 48,
  parameter int unsigned PEAK_WIN  = 32,
  parameter int unsigned FRAME_OFS = 256,
  parameter int unsigned SYM_LEN   = 80,
  parameter int unsigned N_SYM_W   = 8,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               find,
  input  logic [MAG_W-1:0]   corr_mag,
  input  logic [N_SYM_W-1:0] n_sym,
  output logic               det_en,
  output logic               frame_start,
  output logic               sym_start,
  output logic [N_SYM_W-1:0] sym_idx,
  output logic               frame_act,
  output logic [MAG_W-1:0]   peak_mag
`ifdef SYNC_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  localparam int unsigned CW = cnt_width(FRAME_OFS, SYM_LEN, HOLDOFF);

  localparam logic [CW-1:0]      C_ONE     = CW'(1);
  localparam logic [CW-1:0]      WIN_LAST  = CW'(PEAK_WIN - 1);
  localparam logic [CW-1:0]      AGE_LAST  = CW'(FRAME_OFS - 1);
  localparam logic [CW-1:0]      SCNT_LAST = CW'(SYM_LEN - 1);
  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLDOFF - 1);
  localparam logic [N_SYM_W-1:0] S_ONE     = N_SYM_W'(1);

  sync_state_t        state;
  logic [CW-1:0]      win;
  logic [CW-1:0]      scnt;
  logic [CW-1:0]      hcnt;
  logic [N_SYM_W-1:0] nsym_lat;
  logic [MAG_W-1:0]   pk_nxt;
  logic [CW-1:0]      age;
  logic               pt_clear;
  logic               pt_load;
  logic               pt_update;
  logic               pt_age_inc;

  // Peak tracker control decoded from the current state and sample strobe.
  always_comb begin
    pt_clear   = en && (state == HOLD);
    pt_load    = en && (state == SEARCH) && find;
    pt_update  = en && (state == PEAK);
    pt_age_inc = en && (state == ALIGN);
  end

  ofdm_peak_track #(
    .MAG_W (MAG_W),
    .CW    (CW)
  ) u_peak (
    .clk     (clk),
    .rst     (rst),
    .clear   (pt_clear),
    .load    (pt_load),
    .update  (pt_update),
    .age_inc (pt_age_inc),
    .mag     (corr_mag),
    .pk_nxt  (pk_nxt),
    .age     (age)
  );

  // Main sequencer: search, peak window, alignment, symbol timing, hold-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      win         <= '0;
      scnt        <= '0;
      hcnt        <= '0;
      nsym_lat    <= '0;
      det_en      <= 1'b1;
      frame_start <= 1'b0;
      sym_start   <= 1'b0;
      sym_idx     <= '0;
      frame_act   <= 1'b0;
      peak_mag    <= '0;
    end else begin
      frame_start <= 1'b0;
      sym_start   <= 1'b0;
      if (en) begin
        case (state)
          SEARCH: begin
            if (find) begin
              state <= PEAK;
              win   <= C_ONE;
            end
          end
          PEAK: begin
            win <= win + C_ONE;
            if (win == WIN_LAST) begin
              state    <= ALIGN;
              det_en   <= 1'b0;
              peak_mag <= pk_nxt;
            end
          end
          ALIGN: begin
            if (age == AGE_LAST) begin
              state       <= FRAME;
              frame_start <= 1'b1;
              sym_start   <= 1'b1;
              sym_idx     <= '0;
              frame_act   <= 1'b1;
              scnt        <= '0;
              nsym_lat    <= (n_sym == '0) ? S_ONE : n_sym;
            end
          end
          FRAME: begin
            if (scnt == SCNT_LAST) begin
              scnt <= '0;
              if (sym_idx == nsym_lat - S_ONE) begin
                state     <= HOLD;
                frame_act <= 1'b0;
                sym_idx   <= '0;
                hcnt      <= '0;
              end else begin
                sym_idx   <= sym_idx + S_ONE;
                sym_start <= 1'b1;
              end
            end else begin
              scnt <= scnt + C_ONE;
            end
          end
          HOLD: begin
            if (hcnt == HOLD_LAST) begin
              state  <= SEARCH;
              det_en <= 1'b1;
              hcnt   <= '0;
            end else begin
              hcnt <= hcnt + C_ONE;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

`ifdef SYNC_STATS_EN
  // Saturating frame and missed-detection counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      miss_cnt  <= '0;
    end else if (en) begin
      if ((state == ALIGN) && (age == AGE_LAST) && (frame_cnt != '1))
        frame_cnt <= frame_cnt + 16'd1;
      if (find && ((state == HOLD) || (state == ALIGN)) && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_sync_ctrl.sv
// Self-checking bench for ofdm_sync_ctrl: sample-indexed schedule model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ofdm_sync_ctrl;

  localparam int MAG_W     = 48;
  localparam int PEAK_WIN  = 32;
  localparam int FRAME_OFS = 256;
  localparam int SYM_LEN   = 80;
  localparam int N_SYM_W   = 8;
  localparam int HOLDOFF   = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               find;
  logic [MAG_W-1:0]   corr_mag;
  logic [N_SYM_W-1:0] n_sym;
  logic               det_en;
  logic               frame_start;
  logic               sym_start;
  logic [N_SYM_W-1:0] sym_idx;
  logic               frame_act;
  logic [MAG_W-1:0]   peak_mag;
`ifdef SYNC_STATS_EN
  logic [15:0]        frame_cnt;
  logic [15:0]        miss_cnt;
`endif

  ofdm_sync_ctrl #(
    .MAG_W     (MAG_W),
    .PEAK_WIN  (PEAK_WIN),
    .FRAME_OFS (FRAME_OFS),
    .SYM_LEN   (SYM_LEN),
    .N_SYM_W   (N_SYM_W),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .find        (find),
    .corr_mag    (corr_mag),
    .n_sym       (n_sym),
    .det_en      (det_en),
    .frame_start (frame_start),
    .sym_start   (sym_start),
    .sym_idx     (sym_idx),
    .frame_act   (frame_act),
    .peak_mag    (peak_mag)
`ifdef SYNC_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model: absolute sample index k, schedule derived from the find/peak samples.
  int               k, cur_k, phase, s0, mF, mN;
  logic [MAG_W-1:0] winq[$];
  logic             e_det, e_fs, e_ss, e_fa;
  logic [7:0]       e_idx;
  logic [MAG_W-1:0] e_pk;
`ifdef SYNC_STATS_EN
  int               e_fc, e_mc;
`endif

  // Observations for literal checks
  int obs_fs, obs_fa, obs_dr;
  int obs_ss[$];
  logic prev_det;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; k = 0; cur_k = 0; mF = 0; mN = 1;
    winq.delete();
    e_det = 1'b1; e_fs = 1'b0; e_ss = 1'b0; e_fa = 1'b0; e_idx = '0; e_pk = '0;
`ifdef SYNC_STATS_EN
    e_fc = 0; e_mc = 0;
`endif
  endtask

  task automatic note_miss(input bit f);
`ifdef SYNC_STATS_EN
    if (f && e_mc < 65535) e_mc++;
`else
    if (f) begin end
`endif
  endtask

  task automatic model(input bit f, input logic [MAG_W-1:0] m, input logic [7:0] ns);
    e_fs = 1'b0;
    e_ss = 1'b0;
    case (phase)
      0: begin
        if (f) begin
          s0 = k;
          winq.delete();
          winq.push_back(m);
          phase = 1;
        end
      end
      1: begin
        winq.push_back(m);
        if (winq.size() == PEAK_WIN) begin
          int bi;
          bi = 0;
          for (int i = 1; i < winq.size(); i++)
            if (winq[i] > winq[bi]) bi = i;
          e_pk  = winq[bi];
          mF    = s0 + bi + FRAME_OFS;
          e_det = 1'b0;
          phase = 2;
        end
      end
      default: begin
        if (k <= mF) begin
          note_miss(f);
          if (k == mF) begin
            mN = (ns == 0) ? 1 : int'(ns);
            e_fs = 1'b1; e_ss = 1'b1; e_idx = '0; e_fa = 1'b1;
`ifdef SYNC_STATS_EN
            if (e_fc < 65535) e_fc++;
`endif
          end
        end else if (k < mF + mN * SYM_LEN) begin
          e_ss  = ((k - mF) % SYM_LEN) == 0;
          e_idx = 8'((k - mF) / SYM_LEN);
        end else if (k == mF + mN * SYM_LEN) begin
          e_fa  = 1'b0;
          e_idx = '0;
        end else begin
          note_miss(f);
          if (k == mF + mN * SYM_LEN + HOLDOFF) begin
            e_det = 1'b1;
            phase = 0;
          end
        end
      end
    endcase
  endtask

  task automatic step(input bit e, input bit f, input logic [MAG_W-1:0] m, input logic [7:0] ns);
    @(negedge clk);
    en = e; find = f; corr_mag = m; n_sym = ns;
    if (e) begin
      model(f, m, ns);
      cur_k = k;
      k++;
    end else begin
      e_fs = 1'b0;
      e_ss = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; find = 1'b0; corr_mag = '0; n_sym = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  // Directed run: find at fk (value fv), extra magnitudes at ak/bk, optional
  // find at hk, optional 1/0 en toggling; runs until stop_k samples consumed.
  task automatic run_directed(input int fk, input logic [MAG_W-1:0] fv,
                              input int ak, input logic [MAG_W-1:0] av,
                              input int bk, input logic [MAG_W-1:0] bv,
                              input int hk, input bit tog, input logic [7:0] ns,
                              input int stop_k);
    int cyc;
    bit e, f;
    logic [MAG_W-1:0] m;
    obs_fs = -1; obs_fa = 0; obs_dr = -1; obs_ss.delete();
    prev_det = det_en;
    cyc = 0;
    while (k < stop_k && cyc < 4 * stop_k + 100) begin
      e = tog ? (cyc % 2 == 0) : 1'b1;
      f = e && (k == fk || k == hk);
      m = (k == fk) ? fv : (k == ak) ? av : (k == bk) ? bv : '0;
      step(e, f, m, ns);
      if (e) begin
        if (frame_start) obs_fs = cur_k;
        if (sym_start) obs_ss.push_back(cur_k);
        if (frame_act) obs_fa++;
        if (det_en && !prev_det) obs_dr = cur_k;
        prev_det = det_en;
      end
      cyc++;
    end
    chk("directed_budget", 64'(k), 64'(stop_k));
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (!rst && chk_on) begin
      chk("det_en", 64'(det_en), 64'(e_det));
      chk("frame_start", 64'(frame_start), 64'(e_fs));
      chk("sym_start", 64'(sym_start), 64'(e_ss));
      chk("sym_idx", 64'(sym_idx), 64'(e_idx));
      chk("frame_act", 64'(frame_act), 64'(e_fa));
      chk("peak_mag", 64'(peak_mag), 64'(e_pk));
`ifdef SYNC_STATS_EN
      chk("frame_cnt", 64'(frame_cnt), 64'(e_fc));
      chk("miss_cnt", 64'(miss_cnt), 64'(e_mc));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; find = 1'b0; corr_mag = '0; n_sym = '0;
    model_reset();

    // 1: reset state, then idle samples with no find
    do_reset();
    #1;
    chk("rst_det_en", 64'(det_en), 64'd1);
    chk("rst_frame_act", 64'(frame_act), 64'd0);
    chk("rst_peak_mag", 64'(peak_mag), 64'd0);
    chk("rst_sym_idx", 64'(sym_idx), 64'd0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 48'(i * 1000), 8'd3);

    // 2 + 4: peak 500@15, n_sym=3, find in HOLD at sample 520
    do_reset();
    run_directed(10, 48'd100, 15, 48'd500, 20, 48'd300, 520, 1'b0, 8'd3, 580);
    chk("t2_model_F", 64'(mF), 64'd271);
    chk("t2_frame_start_k", 64'(obs_fs), 64'd271);
    chk("t2_peak_mag", 64'(peak_mag), 64'd500);
    chk("t4_sym_start_cnt", 64'(obs_ss.size()), 64'd3);
    if (obs_ss.size() == 3) begin
      chk("t4_sym_start0", 64'(obs_ss[0]), 64'd271);
      chk("t4_sym_start1", 64'(obs_ss[1]), 64'd351);
      chk("t4_sym_start2", 64'(obs_ss[2]), 64'd431);
    end
    chk("t4_frame_act_len", 64'(obs_fa), 64'd240);
    chk("t4_det_en_rise_k", 64'(obs_dr), 64'd575);
`ifdef SYNC_STATS_EN
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t2_miss_cnt", 64'(miss_cnt), 64'd1);
`endif

    // 3: tie 400@12 and 400@30 keeps the earlier peak
    do_reset();
    run_directed(12, 48'd400, 30, 48'd400, 20, 48'd50, -1, 1'b0, 8'd1, 440);
    chk("t3_frame_start_k", 64'(obs_fs), 64'd268);
    chk("t3_peak_mag", 64'(peak_mag), 64'd400);

    // 5: en toggling 1/0 gives identical sample timing
    do_reset();
    run_directed(10, 48'd100, 15, 48'd500, 20, 48'd300, 520, 1'b1, 8'd3, 580);
    chk("t5_frame_start_k", 64'(obs_fs), 64'd271);
    chk("t5_frame_act_len", 64'(obs_fa), 64'd240);
    chk("t5_det_en_rise_k", 64'(obs_dr), 64'd575);
`ifdef SYNC_STATS_EN
    chk("t5_miss_cnt", 64'(miss_cnt), 64'd1);
`endif

    // 6: async reset during symbol 1 of a frame, then a clean search
    do_reset();
    run_directed(10, 48'd100, 15, 48'd500, 20, 48'd300, -1, 1'b0, 8'd3, 360);
    chk("t6_in_sym1", 64'(sym_idx), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_frame_act", 64'(frame_act), 64'd0);
    chk("t6_rst_sym_idx", 64'(sym_idx), 64'd0);
    chk("t6_rst_det_en", 64'(det_en), 64'd1);
    chk("t6_rst_peak_mag", 64'(peak_mag), 64'd0);
    chk_on = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    run_directed(5, 48'd777, 9, 48'd900, 20, 48'd100, -1, 1'b0, 8'd2, 300);
    chk("t6_frame_start_k", 64'(obs_fs), 64'd265);
    chk("t6_peak_mag", 64'(peak_mag), 64'd900);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      bit e, f;
      logic [63:0] r;
      logic [MAG_W-1:0] m;
      e = ($urandom % 4) != 0;
      f = e && (($urandom % 24) == 0);
      r = {32'($urandom), 32'($urandom)};
      m = ($urandom % 2 == 0) ? 48'(($urandom % 8) * 100) : r[47:0];
      step(e, f, m, 8'($urandom % 4));
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
